// File: rtl/icache.sv
// Direct-mapped instruction cache between IF and the memory controller's instruction port.
// One 32-bit word per line; hits answer in one cycle, misses fetch one word and fill the line.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  jump_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_valid_out,
    output logic [31:0]           if_inst_out,
    output logic                  if_busy_out,
    output logic                  mc_req_out,
    output logic [ADDR_WIDTH-1:0] mc_addr_out,
    input  logic                  mc_valid_in,
    input  logic [31:0]           mc_data_in
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-3:0]   miss_addr_reg, miss_addr_next;
    logic                    if_valid_reg, if_valid_next;
    logic [31:0]             if_inst_reg, if_inst_next;
    logic                    if_busy_reg, if_busy_next;
    logic                    mc_req_reg, mc_req_next;

    logic [LINES-1:0]        valid_reg;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];

    logic [INDEX_BITS-1:0]   req_index;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic                    addr_lsb_unused;

    // Byte offset within the word carries no information for an instruction fetch.
    assign addr_lsb_unused = ^if_addr_in[1:0];

    assign req_index  = if_addr_in[INDEX_BITS+1:2];
    assign req_tag    = if_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_index = miss_addr_reg[INDEX_BITS-1:0];
    assign fill_tag   = miss_addr_reg[ADDR_WIDTH-3:INDEX_BITS];

    // Lookup must resolve in the request cycle so the word is registered out one cycle later.
    assign hit     = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
    // A returning word is written even when a flush arrives with it; the data is correct for its address.
    assign fill_en = (state_reg == MISS) && mc_valid_in && !rst_in;

    always_comb begin
        state_next     = state_reg;
        miss_addr_next = miss_addr_reg;
        if_valid_next  = 1'b0;
        if_inst_next   = if_inst_reg;
        if_busy_next   = if_busy_reg;
        mc_req_next    = mc_req_reg;
        case (state_reg)
            IDLE: begin
                if (!jump_in && if_req_in) begin
                    if (hit) begin
                        if_valid_next = 1'b1;
                        if_inst_next  = data_mem[req_index];
                    end else begin
                        miss_addr_next = if_addr_in[ADDR_WIDTH-1:2];
                        mc_req_next    = 1'b1;
                        if_busy_next   = 1'b1;
                        state_next     = MISS;
                    end
                end
            end
            MISS: begin
                if (mc_valid_in || jump_in) begin
                    mc_req_next  = 1'b0;
                    if_busy_next = 1'b0;
                    state_next   = IDLE;
                    if (mc_valid_in && !jump_in) begin
                        if_valid_next = 1'b1;
                        if_inst_next  = mc_data_in;
                    end
                end
            end
            default: begin
                mc_req_next  = 1'b0;
                if_busy_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
            if_valid_reg  <= 1'b0;
            if_inst_reg   <= '0;
            if_busy_reg   <= 1'b0;
            mc_req_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            miss_addr_reg <= miss_addr_next;
            if_valid_reg  <= if_valid_next;
            if_inst_reg   <= if_inst_next;
            if_busy_reg   <= if_busy_next;
            mc_req_reg    <= mc_req_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mc_data_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (fill_index == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign if_valid_out = if_valid_reg;
    assign if_inst_out  = if_inst_reg;
    assign if_busy_out  = if_busy_reg;
    assign mc_req_out   = mc_req_reg;
    assign mc_addr_out  = {miss_addr_reg, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a per-cycle vector table for hit/miss/conflict traffic,
// then hand-written sequences for long stalls, flushes and reset during a miss.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        jump_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_valid_out;
    logic [31:0] if_inst_out;
    logic        if_busy_out;
    logic        mc_req_out;
    logic [31:0] mc_addr_out;
    logic        mc_valid_in;
    logic [31:0] mc_data_in;

    int tests_run = 0;
    int tests_failed = 0;

    icache #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .jump_in     (jump_in),
        .if_req_in   (if_req_in),
        .if_addr_in  (if_addr_in),
        .if_valid_out(if_valid_out),
        .if_inst_out (if_inst_out),
        .if_busy_out (if_busy_out),
        .mc_req_out  (mc_req_out),
        .mc_addr_out (mc_addr_out),
        .mc_valid_in (mc_valid_in),
        .mc_data_in  (mc_data_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        jump;
        logic        mcv;
        logic [31:0] mdata;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_busy;
        logic        e_mcreq;
        logic [31:0] e_mcaddr;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic jump,
                                input logic mcv, input logic [31:0] mdata, input logic e_valid,
                                input logic [31:0] e_inst, input logic e_busy, input logic e_mcreq,
                                input logic [31:0] e_mcaddr);
        vec_t v;
        v.req = req; v.addr = addr; v.jump = jump; v.mcv = mcv; v.mdata = mdata;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_busy = e_busy;
        v.e_mcreq = e_mcreq; v.e_mcaddr = e_mcaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic req, input logic [31:0] addr, input logic jump,
                         input logic mcv, input logic [31:0] mdata);
        @(negedge clk_in);
        if_req_in   = req;
        if_addr_in  = addr;
        jump_in     = jump;
        mc_valid_in = mcv;
        mc_data_in  = mdata;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_valid, input logic [31:0] e_inst,
                              input logic e_busy, input logic e_mcreq, input logic [31:0] e_mcaddr);
        check({tag, " valid"}, {31'd0, if_valid_out}, {31'd0, e_valid});
        check({tag, " busy"},  {31'd0, if_busy_out},  {31'd0, e_busy});
        check({tag, " mc_req"}, {31'd0, mc_req_out},  {31'd0, e_mcreq});
        if (e_valid) check({tag, " inst"}, if_inst_out, e_inst);
        if (e_mcreq) check({tag, " mc_addr"}, mc_addr_out, e_mcaddr);
    endtask

    initial begin
        // req addr jump mcv mdata | valid inst busy mcreq mcaddr
        vecs[0]  = mk(1, 32'h004, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h004);
        vecs[1]  = mk(1, 32'h080, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h004);
        vecs[2]  = mk(1, 32'h080, 0, 1, 32'h00A00093, 1, 32'h00A00093, 0, 0, 32'h0);
        vecs[3]  = mk(1, 32'h004, 0, 0, 32'h0,        1, 32'h00A00093, 0, 0, 32'h0);
        vecs[4]  = mk(0, 32'h004, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);
        vecs[5]  = mk(1, 32'h000, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h000);
        vecs[6]  = mk(0, 32'h000, 0, 1, 32'h11111111, 1, 32'h11111111, 0, 0, 32'h0);
        vecs[7]  = mk(1, 32'h000, 0, 0, 32'h0,        1, 32'h11111111, 0, 0, 32'h0);
        vecs[8]  = mk(1, 32'h202, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h200);
        vecs[9]  = mk(0, 32'h000, 0, 1, 32'h22222222, 1, 32'h22222222, 0, 0, 32'h0);
        vecs[10] = mk(1, 32'h200, 0, 0, 32'h0,        1, 32'h22222222, 0, 0, 32'h0);
        vecs[11] = mk(1, 32'h000, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h000);
        vecs[12] = mk(0, 32'h000, 0, 1, 32'h33333333, 1, 32'h33333333, 0, 0, 32'h0);
        vecs[13] = mk(1, 32'h004, 0, 0, 32'h0,        1, 32'h00A00093, 0, 0, 32'h0);
        vecs[14] = mk(1, 32'h000, 0, 0, 32'h0,        1, 32'h33333333, 0, 0, 32'h0);
        vecs[15] = mk(1, 32'h004, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);

        rst_in = 1'b1; jump_in = 1'b0; if_req_in = 1'b0; if_addr_in = '0;
        mc_valid_in = 1'b0; mc_data_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset valid",   {31'd0, if_valid_out}, 32'd0);
        check("reset inst",    if_inst_out, 32'd0);
        check("reset busy",    {31'd0, if_busy_out}, 32'd0);
        check("reset mc_req",  {31'd0, mc_req_out}, 32'd0);
        check("reset mc_addr", mc_addr_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].jump, vecs[i].mcv, vecs[i].mdata);
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst,
                       vecs[i].e_busy, vecs[i].e_mcreq, vecs[i].e_mcaddr);
            $display("[TB] vec %0d req=%0b addr=0x%08h jump=%0b mcv=%0b -> valid=%0b inst=0x%08h busy=%0b mc_req=%0b",
                     i, vecs[i].req, vecs[i].addr, vecs[i].jump, vecs[i].mcv,
                     if_valid_out, if_inst_out, if_busy_out, mc_req_out);
        end

        // Long stall on 0x10 then a flush aborts it without filling.
        drive(1, 32'h010, 0, 0, 32'h0);
        check_outs("stall start", 0, 32'h0, 1, 1, 32'h010);
        for (int c = 0; c < 20; c++) begin
            drive(1, 32'h3F0, 0, 0, 32'h0);
            check_outs($sformatf("stall c%0d", c), 0, 32'h0, 1, 1, 32'h010);
        end
        drive(1, 32'h010, 1, 0, 32'h0);
        check_outs("abort", 0, 32'h0, 0, 0, 32'h0);
        drive(0, 32'h010, 0, 0, 32'h0);
        check_outs("after abort", 0, 32'h0, 0, 0, 32'h0);
        drive(1, 32'h010, 0, 0, 32'h0);
        check_outs("0x10 misses again", 0, 32'h0, 1, 1, 32'h010);
        drive(0, 32'h0, 0, 1, 32'h44444444);
        check_outs("0x10 fill", 1, 32'h44444444, 0, 0, 32'h0);
        $display("[TB] stall/abort sequence on 0x10 done");

        // Flush coincident with fill: no valid pulse, but the line is written.
        drive(1, 32'h020, 0, 0, 32'h0);
        check_outs("0x20 miss", 0, 32'h0, 1, 1, 32'h020);
        drive(0, 32'h0, 1, 1, 32'h55555555);
        check_outs("jump+fill", 0, 32'h0, 0, 0, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0);
        check_outs("post jump+fill", 0, 32'h0, 0, 0, 32'h0);
        drive(1, 32'h020, 0, 0, 32'h0);
        check_outs("0x20 hit", 1, 32'h55555555, 0, 0, 32'h0);
        $display("[TB] jump+fill sequence on 0x20 done");

        // Reset during a miss clears everything, including the valid bits.
        drive(1, 32'h040, 0, 0, 32'h0);
        check_outs("0x40 miss", 0, 32'h0, 1, 1, 32'h040);
        @(negedge clk_in);
        rst_in = 1'b1; if_req_in = 1'b0; mc_valid_in = 1'b1; mc_data_in = 32'h66666666;
        @(posedge clk_in);
        #1;
        check("midrst valid",   {31'd0, if_valid_out}, 32'd0);
        check("midrst inst",    if_inst_out, 32'd0);
        check("midrst busy",    {31'd0, if_busy_out}, 32'd0);
        check("midrst mc_req",  {31'd0, mc_req_out}, 32'd0);
        check("midrst mc_addr", mc_addr_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0; mc_valid_in = 1'b0;
        drive(1, 32'h004, 0, 0, 32'h0);
        check_outs("0x4 misses after reset", 0, 32'h0, 1, 1, 32'h004);
        drive(0, 32'h0, 0, 1, 32'h77777777);
        check_outs("0x4 refill", 1, 32'h77777777, 0, 0, 32'h0);
        $display("[TB] reset-during-miss sequence done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
